led_matrix_scan_pwm: RTL

- Parametrised row-scanned driver for a bicolour (red/green) LED matrix. Each pixel has a BPP-bit intensity, rendered by per-row PWM.
- Adds a blanking interval between rows to prevent ghosting.
- Double-buffers the frame, with a swap handshake so game logic can update the frame at any time without tearing.
- Sits between the game-state/render logic and the board GPIO.

---
 rtl/led_matrix_scan_pwm_pkg.sv | 41 ++++
 rtl/led_matrix_scan_pwm_if.sv | 27 ++
 rtl/led_matrix_scan_pwm_row_compare.sv | 19 +
 rtl/led_matrix_scan_pwm.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/led_matrix_scan_pwm_pkg.sv
// rtl/led_matrix_scan_pwm_pkg.sv - shared scan states, geometry helpers and frame pixel indexing
package led_matrix_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BLANK  = 2'd1,
      ACTIVE = 2'd2
   } scan_state_t;

   // Geometry of the default board build.
   localparam int DEFAULT_ROWS = 8;
   localparam int DEFAULT_BPP  = 2;
   localparam int PWM_SLOTS    = (1 << DEFAULT_BPP) - 1;
   localparam int ROW_W        = $clog2(DEFAULT_ROWS);

   // Upper bounds accepted by pixel_at; frames are zero-extended to this width.
   localparam int MAX_FRAME_W = 4096;
   localparam int MAX_BPP     = 8;

   // Number of PWM slots per row for a given intensity depth.
   function automatic int pwm_slots_of(input int bpp);
      return (1 << bpp) - 1;
   endfunction

   // Bits needed to count 0..n-1, never less than one.
   function automatic int width_of(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Intensity of pixel [r][c] in a flattened frame, right-aligned.
   function automatic logic [MAX_BPP-1:0] pixel_at(input logic [MAX_FRAME_W-1:0] frame,
                                                   input int r,
                                                   input int c,
                                                   input int cols,
                                                   input int bpp);
      logic [MAX_BPP-1:0] mask;
      mask = (MAX_BPP'(1) << bpp) - MAX_BPP'(1);
      return MAX_BPP'(frame >> ((r * cols + c) * bpp)) & mask;
   endfunction

endpackage

// File: rtl/led_matrix_scan_pwm_if.sv
// rtl/led_matrix_scan_pwm_if.sv - frame hand-over bus between render logic and the matrix driver
interface led_matrix_if #(
   parameter int ROWS = 8,
   parameter int COLS = 8,
   parameter int BPP  = 2
);
   logic [ROWS*COLS*BPP-1:0] red_frame;
   logic [ROWS*COLS*BPP-1:0] green_frame;
   logic                     swap_req;
   logic                     swap_ack;

   // Render logic side: offers a frame and requests a swap.
   modport master (
      output red_frame,
      output green_frame,
      output swap_req,
      input  swap_ack
   );

   // Matrix driver side: captures the frame at a frame boundary.
   modport slave (
      input  red_frame,
      input  green_frame,
      input  swap_req,
      output swap_ack
   );
endinterface

// File: rtl/led_matrix_scan_pwm_row_compare.sv
// rtl/led_matrix_scan_pwm_row_compare.sv - per-column PWM threshold compare for one colour of one row
module led_pwm_row_compare #(
   parameter int COLS = 8,
   parameter int BPP  = 2
) (
   input  logic [COLS*BPP-1:0] intensity,
   input  logic [BPP-1:0]      pwm_p,
   output logic [COLS-1:0]     lit
);

   // A column is lit while its intensity exceeds the current PWM step.
   always_comb begin
      lit = '0;
      for (int c = 0; c < COLS; c++) begin
         lit[c] = (intensity[c*BPP +: BPP] > pwm_p);
      end
   end

endmodule

// File: rtl/led_matrix_scan_pwm.sv
// rtl/led_matrix_scan_pwm.sv - row-scanned bicolour LED matrix driver with PWM, blanking and double-buffered frames
module led_matrix_scan_pwm
   import led_matrix_pkg::*;
#(
   parameter int ROWS           = 8,
   parameter int COLS           = 8,
   parameter int BPP            = 2,
   parameter int SLOT_CLKS      = 4,
   parameter int BLANK_CLKS     = 2,
   parameter bit ROW_ACTIVE_LOW = 1'b1,
   parameter bit COL_ACTIVE_LOW = 1'b0
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   led_matrix_if.slave             frame_bus,
   output logic                    frame_start,
   output logic [$clog2(ROWS)-1:0] row_idx,
   output logic [COLS-1:0]         red_driver,
   output logic [COLS-1:0]         green_driver,
   output logic [ROWS-1:0]         row_sink
);

   localparam int SLOTS    = pwm_slots_of(BPP);
   localparam int ROW_BITS = $clog2(ROWS);
   localparam int CNT_W    = width_of((SLOT_CLKS > BLANK_CLKS) ? SLOT_CLKS : BLANK_CLKS);
   localparam int FRAME_W  = ROWS * COLS * BPP;

   localparam logic [ROW_BITS-1:0] ROW_LAST   = ROW_BITS'(ROWS - 1);
   localparam logic [CNT_W-1:0]    BLANK_LAST = CNT_W'(BLANK_CLKS - 1);
   localparam logic [CNT_W-1:0]    SLOT_LAST  = CNT_W'(SLOT_CLKS - 1);
   localparam logic [BPP-1:0]      P_LAST     = BPP'(SLOTS - 1);

   // Dark levels; XOR with these also applies the active polarity to lit bits.
   localparam logic [COLS-1:0] COL_OFF = COL_ACTIVE_LOW ? {COLS{1'b1}} : {COLS{1'b0}};
   localparam logic [ROWS-1:0] ROW_OFF = ROW_ACTIVE_LOW ? {ROWS{1'b1}} : {ROWS{1'b0}};

   scan_state_t         state, state_nx;
   logic [ROW_BITS-1:0] row, row_nx;
   logic [CNT_W-1:0]    cnt, cnt_nx;
   logic [BPP-1:0]      pwm_p, p_nx;

   logic               boundary;
   logic               swap_take;
   logic               pending;
   logic [FRAME_W-1:0] shadow_red;
   logic [FRAME_W-1:0] shadow_green;

   logic [COLS*BPP-1:0] row_red;
   logic [COLS*BPP-1:0] row_green;
   logic [COLS-1:0]     lit_red;
   logic [COLS-1:0]     lit_green;
   logic [ROWS-1:0]     row_sel;

   // Scan state and counters advance every clock.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= BLANK;
         row   <= '0;
         cnt   <= '0;
         pwm_p <= '0;
      end else begin
         state <= state_nx;
         row   <= row_nx;
         cnt   <= cnt_nx;
         pwm_p <= p_nx;
      end
   end

   // Next scan position: blank interval, PWM slots, then the following row.
   always_comb begin
      state_nx = state;
      row_nx   = row;
      cnt_nx   = cnt;
      p_nx     = pwm_p;
      unique case (state)
         IDLE: begin
            row_nx = '0;
            cnt_nx = '0;
            p_nx   = '0;
            if (enable) begin
               state_nx = BLANK;
            end
         end
         BLANK: begin
            if (!enable) begin
               state_nx = IDLE;
               row_nx   = '0;
               cnt_nx   = '0;
               p_nx     = '0;
            end else if (cnt == BLANK_LAST) begin
               state_nx = ACTIVE;
               cnt_nx   = '0;
               p_nx     = '0;
            end else begin
               cnt_nx = cnt + CNT_W'(1);
            end
         end
         ACTIVE: begin
            if (!enable) begin
               state_nx = IDLE;
               row_nx   = '0;
               cnt_nx   = '0;
               p_nx     = '0;
            end else if (cnt != SLOT_LAST) begin
               cnt_nx = cnt + CNT_W'(1);
            end else begin
               cnt_nx = '0;
               if (pwm_p != P_LAST) begin
                  p_nx = pwm_p + BPP'(1);
               end else begin
                  state_nx = BLANK;
                  p_nx     = '0;
                  row_nx   = (row == ROW_LAST) ? '0 : row + ROW_BITS'(1);
               end
            end
         end
         default: begin
            state_nx = BLANK;
            row_nx   = '0;
            cnt_nx   = '0;
            p_nx     = '0;
         end
      endcase
   end

   // The first blank cycle of row 0 is the only place a new frame may be taken.
   assign boundary  = (state == BLANK) && (row == '0) && (cnt == '0) && enable;
   assign swap_take = boundary && (pending || frame_bus.swap_req);

   assign frame_start        = boundary;
   assign frame_bus.swap_ack = swap_take;
   assign row_idx            = row;

   // Shadow frames and the outstanding swap request.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending      <= 1'b0;
         shadow_red   <= '0;
         shadow_green <= '0;
      end else if (swap_take) begin
         pending      <= 1'b0;
         shadow_red   <= frame_bus.red_frame;
         shadow_green <= frame_bus.green_frame;
      end else if (frame_bus.swap_req) begin
         pending <= 1'b1;
      end
   end

   // Gather the intensities of the row being scanned from the shadow frames.
   always_comb begin
      row_red   = '0;
      row_green = '0;
      for (int c = 0; c < COLS; c++) begin
         row_red[c*BPP +: BPP]   = BPP'(pixel_at(MAX_FRAME_W'(shadow_red), int'(row), c, COLS, BPP));
         row_green[c*BPP +: BPP] = BPP'(pixel_at(MAX_FRAME_W'(shadow_green), int'(row), c, COLS, BPP));
      end
   end

   led_pwm_row_compare #(
      .COLS (COLS),
      .BPP  (BPP)
   ) u_cmp_red (
      .intensity (row_red),
      .pwm_p     (pwm_p),
      .lit       (lit_red)
   );

   led_pwm_row_compare #(
      .COLS (COLS),
      .BPP  (BPP)
   ) u_cmp_green (
      .intensity (row_green),
      .pwm_p     (pwm_p),
      .lit       (lit_green)
   );

   assign row_sel = ROWS'(1) << row;

   // Drivers and row select are registered together so they always switch on the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         red_driver   <= COL_OFF;
         green_driver <= COL_OFF;
         row_sink     <= ROW_OFF;
      end else if (state == ACTIVE) begin
         red_driver   <= lit_red ^ COL_OFF;
         green_driver <= lit_green ^ COL_OFF;
         row_sink     <= row_sel ^ ROW_OFF;
      end else begin
         red_driver   <= COL_OFF;
         green_driver <= COL_OFF;
         row_sink     <= ROW_OFF;
      end
   end

endmodule
